mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: the maximum number of consecutive owned cycles while the other requester waits (legal range 2..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports req0 / req1, input, 1 bit each: bus request from requester 0 (processor) and requester 1 (I/O/DMA).
REQ-005 SHALL have ports addr0 / addr1, input, 16 bits each: the requester address.
REQ-006 SHALL have ports dout0 / dout1, input, 16 bits each: the requester write data.
REQ-007 SHALL have ports we0 / we1, input, 1 bit each: the requester write enable.
REQ-008 SHALL have ports gnt0 / gnt1, output, 1 bit each: registered grant; at most one is high at a time.
REQ-009 SHALL have port mem_addr, output, 16 bits: the memory address.
REQ-010 SHALL have port mem_din, output, 16 bits: the memory write data.
REQ-011 SHALL have port mem_we, output, 1 bit: the memory write enable.
REQ-012 SHALL have port mem_dout, input, 16 bits: the memory read data.
REQ-013 SHALL have port rdata, output, 16 bits: mem_dout passed through combinationally to both requesters.
REQ-014 SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, OWN0, OWN1; gnt0 = (state==OWN0); gnt1 = (state==OWN1).
REQ-016 IDLE: no req -> stay; exactly one req -> OWN of that requester; both -> tie rule (REQ-022); grant visible the cycle after req is sampled (1-cycle latency).
REQ-017 OWNx, reqx low -> OWN of the other requester if its req is high, else IDLE; no dead cycle on handover.
REQ-018 OWNx, reqx high and other req low -> stay in OWNx indefinitely; burst counter holds at saturation.
REQ-019 OWNx, reqx high and other req high -> switch to the other requester when burst count == MAX_BURST-1, i.e. after exactly MAX_BURST owned cycles.
REQ-020 Burst counter: 4 bits; cleared on every state change, including IDLE entry; increments each cycle in OWN, saturating at MAX_BURST-1.
REQ-021 mem_addr, mem_din and we SHALL be muxed combinationally from the owner; mem_we = wex & reqx & gntx; in IDLE mem_addr=0, mem_din=0, mem_we=0.
REQ-022 Tie rule in IDLE: per Configuration; the last-grant register is updated on every entry to OWNx.
REQ-023 A requester dropping req in the same cycle the other raises req SHALL follow REQ-017 (handover to the other).
REQ-024 A write SHALL never issue for a non-owner, including on the grant cycle boundary.

Reset
REQ-025 On reset high, immediately: state=IDLE, gnt0=gnt1=0, busy=0, counter=0, last-grant=1, mem_we=0.
REQ-026 Reset asserted mid-burst SHALL abort ownership without a completing write; the first grant after release follows REQ-016.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: an IDLE tie goes to the requester not most recently granted (requester 0 wins first after reset).
REQ-028 Macro ARB_ROUND_ROBIN_EN undefined: an IDLE tie always goes to requester 0, and the last-grant register is omitted; the burst limit applies in both builds.

Verification
REQ-029 req0=1 alone, addr0=16'h0010, we0=1, dout0=16'h00AB -> gnt0=1 next cycle; mem_addr=16'h0010, mem_din=16'h00AB, mem_we=1.
REQ-030 req0 and req1 held high from IDLE, MAX_BURST=4 -> gnt0 for 4 cycles, then gnt1 for 4 cycles, alternating; never both high.
REQ-031 OWN0, req0 drops while req1=1 -> gnt1=1 the next cycle with no IDLE cycle; busy stays 1.
REQ-032 Back-to-back ties with ARB_ROUND_ROBIN_EN: grants 0,1,0; without the macro: 0,0,0.
REQ-033 Reset pulsed during OWN1 with we1=1 -> gnt1=0 and mem_we=0 immediately; after release with req0=1 -> gnt0=1 one cycle later.
REQ-034 req1=1, we1=0, mem_dout=16'h1234 -> rdata=16'h1234 and mem_we=0 for every cycle of ownership.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// mem_bus_arbiter
//   Two-requester memory bus arbiter. Requester 0 is the processor and
//   requester 1 is I/O/DMA. Ownership is tracked by a three-state FSM
//   (IDLE, OWN0, OWN1). A requester may hold the bus indefinitely while the
//   other is idle. While both are requesting, the owner is limited to
//   MAX_BURST consecutive cycles. The owner's address, write data and write
//   enable are steered to memory combinationally. Read data goes back to
//   both requesters unchanged.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : an IDLE tie goes to the requester not most recently granted
//                 (requester 0 wins the first tie after reset)
//     undefined : an IDLE tie always goes to requester 0
//
// Ports
//   clk              clock, all state changes on its rising edge
//   reset            asynchronous, active-high reset
//   req0/req1        bus requests
//   addr0/addr1      requester addresses (16 bits)
//   dout0/dout1      requester write data (16 bits)
//   we0/we1          requester write enables
//   gnt0/gnt1        registered grants (mutually exclusive)
//   mem_addr         memory address (0 when idle)
//   mem_din          memory write data (0 when idle)
//   mem_we           memory write enable (owner's we & req)
//   mem_dout         memory read data
//   rdata            mem_dout passed through to both requesters
//   busy             high whenever the bus is owned
module mem_bus_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] dout0,
  input  logic [15:0] dout1,
  input  logic        we0,
  input  logic        we1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  input  logic [15:0] mem_dout,
  output logic [15:0] rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] burst_cnt;
  logic       tie_pick1;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = requester 1 was granted most recently; reset value lets requester 0
  // win the first tie.
  logic last_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_gnt <= 1'b1;
    else if (state_nxt != state && state_nxt != IDLE)
      last_gnt <= (state_nxt == OWN1);
  end

  assign tie_pick1 = ~last_gnt;
`else
  assign tie_pick1 = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1)
          state_nxt = tie_pick1 ? OWN1 : OWN0;
        else if (req0)
          state_nxt = OWN0;
        else if (req1)
          state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0)
          state_nxt = req1 ? OWN1 : IDLE;
        else if (req1 && burst_cnt == BURST_LAST)
          state_nxt = OWN1;
      end
      OWN1: begin
        if (!req1)
          state_nxt = req0 ? OWN0 : IDLE;
        else if (req0 && burst_cnt == BURST_LAST)
          state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grants and busy are registered from the next state, so they always
  // match the state register without a decode after the flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      gnt0  <= (state_nxt == OWN0);
      gnt1  <= (state_nxt == OWN1);
      busy  <= (state_nxt != IDLE);
      if (state_nxt != state)
        burst_cnt <= '0;
      else if (state != IDLE && burst_cnt != BURST_LAST)
        burst_cnt <= burst_cnt + 4'd1;
    end
  end

  // A write is issued only when the owner is still requesting. This blocks
  // a stale write in the cycle an owner drops req.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (gnt0) begin
      mem_addr = addr0;
      mem_din  = dout0;
      mem_we   = we0 & req0;
    end else if (gnt1) begin
      mem_addr = addr1;
      mem_din  = dout1;
      mem_we   = we1 & req1;
    end
  end

  assign rdata = mem_dout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int unsigned MB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, dout0 = '0, dout1 = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [15:0] mem_dout = '0;
  logic        gnt0, gnt1, mem_we, busy;
  logic [15:0] mem_addr, mem_din, rdata;

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 none), cycles owned so far, last granted.
  int m_owner = -1;
  int m_streak = 0;
  int m_last = 1;

  mem_bus_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .dout0(dout0), .dout1(dout1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_owner = -1;
    m_streak = 0;
    m_last = 1;
  endtask

  function automatic int tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
    return 1 - m_last;
`else
    return 0;
`endif
  endfunction

  task automatic model_step();
    int  nxt;
    bit  mine, other;
    if (m_owner == -1) begin
      if (req0 && req1) nxt = tie_winner();
      else if (req0)    nxt = 0;
      else if (req1)    nxt = 1;
      else              nxt = -1;
    end else begin
      mine  = (m_owner == 0) ? req0 : req1;
      other = (m_owner == 0) ? req1 : req0;
      if (!mine)                           nxt = other ? 1 - m_owner : -1;
      else if (other && m_streak >= int'(MB)) nxt = 1 - m_owner;
      else                                 nxt = m_owner;
    end
    if (nxt != m_owner) begin
      m_streak = (nxt == -1) ? 0 : 1;
      if (nxt != -1) m_last = nxt;
    end else if (nxt != -1) begin
      m_streak++;
    end
    m_owner = nxt;
  endtask

  // Expected {gnt0,gnt1,busy,mem_we,mem_addr,mem_din,rdata}
  function automatic logic [51:0] exp_vec();
    logic [15:0] a = '0;
    logic [15:0] d = '0;
    logic        w = 1'b0;
    if (m_owner == 0) begin a = addr0; d = dout0; w = we0 & req0; end
    if (m_owner == 1) begin a = addr1; d = dout1; w = we1 & req1; end
    return {m_owner == 0, m_owner == 1, m_owner != -1, w, a, d, mem_dout};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1; we0 = 1; addr0 = 16'h5555; dout0 = 16'hAAAA;
    #1;
    checks++;
    if ({gnt0, gnt1, busy, mem_we, mem_addr} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0", {gnt0, gnt1, busy, mem_we, mem_addr});
    end
    @(posedge clk); #1; @(posedge clk); #1;
    checks++;
    if ({gnt0, gnt1, busy, mem_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b required 0000", {gnt0, gnt1, busy, mem_we});
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    req0 = 1; addr0 = 16'h0010; we0 = 1; dout0 = 16'h00AB;
    #1;
    checks++;
    if (gnt0 !== 1'b0) begin
      errors++; $display("FAIL write_latency: gnt0 got %b required 0", gnt0);
    end
    tick();
    checks++;
    if ({gnt0, mem_addr, mem_din, mem_we} !== {1'b1, 16'h0010, 16'h00AB, 1'b1}) begin
      errors++;
      $display("FAIL single_write: got gnt0=%b addr=%h din=%h we=%b required 1 0010 00ab 1",
               gnt0, mem_addr, mem_din, mem_we);
    end
    req0 = 0; we0 = 0;
    tick();
  endtask

  task automatic test_alternating();
    logic e0;
    do_reset();
    req0 = 1; req1 = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      e0 = ((k / MB) % 2) == 0;
      checks++;
      if ({gnt0, gnt1} !== {e0, ~e0}) begin
        errors++;
        $display("FAIL alternate cycle %0d: got gnt=%b%b required %b%b", k, gnt0, gnt1, e0, ~e0);
      end
    end
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_handover();
    do_reset();
    req0 = 1; we0 = 1;
    tick(); tick();
    req0 = 0; req1 = 1; we1 = 0;
    #1;
    checks++;
    if ({gnt0, mem_we} !== 2'b10) begin
      errors++; $display("FAIL drop_no_write: got gnt0,we=%b%b required 10", gnt0, mem_we);
    end
    tick();
    checks++;
    if ({gnt0, gnt1, busy} !== 3'b011) begin
      errors++; $display("FAIL handover: got gnt0,gnt1,busy=%b%b%b required 011", gnt0, gnt1, busy);
    end
    req1 = 0; we0 = 0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL release_idle: busy got %b required 0", busy);
    end
  endtask

  task automatic test_tie_sequence();
    int exp_seq[3];
    int got;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0};
`else
    exp_seq = '{0, 0, 0};
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req0 = 1; req1 = 1;
      tick();
      got = gnt1 ? 1 : 0;
      checks++;
      if ((gnt0 ^ gnt1) !== 1'b1 || got != exp_seq[i]) begin
        errors++;
        $display("FAIL tie %0d: got gnt=%b%b required owner %0d", i, gnt0, gnt1, exp_seq[i]);
      end
      req0 = 0; req1 = 0;
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req1 = 1; we1 = 1; addr1 = 16'h0BEE; dout1 = 16'h1111;
    tick(); tick();
    checks++;
    if ({gnt1, mem_we} !== 2'b11) begin
      errors++; $display("FAIL own1_write: got gnt1,we=%b%b required 11", gnt1, mem_we);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({gnt1, mem_we, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_abort: got gnt1,we,busy=%b%b%b required 000", gnt1, mem_we, busy);
    end
    reset = 1'b0; req1 = 0; we1 = 0; req0 = 1;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("FAIL post_reset_grant: got gnt=%b%b required 10", gnt0, gnt1);
    end
    req0 = 0;
    tick();
  endtask

  task automatic test_read_passthrough();
    do_reset();
    req1 = 1; we1 = 0; mem_dout = 16'h1234;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({gnt1, rdata, mem_we} !== {1'b1, 16'h1234, 1'b0}) begin
        errors++;
        $display("FAIL read_pass cycle %0d: got gnt1=%b rdata=%h we=%b required 1 1234 0",
                 k, gnt1, rdata, mem_we);
      end
    end
    req1 = 0;
    tick();
  endtask

  task automatic test_random();
    logic [51:0] act, exp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      req0 = ($urandom_range(3) != 0);
      req1 = ($urandom_range(3) != 0);
      we0 = $urandom_range(1) != 0;
      we1 = $urandom_range(1) != 0;
      addr0 = 16'($urandom); addr1 = 16'($urandom);
      dout0 = 16'($urandom); dout1 = 16'($urandom);
      mem_dout = 16'($urandom);
      if ($urandom_range(99) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      #1;
      act = {gnt0, gnt1, busy, mem_we, mem_addr, mem_din, rdata};
      exp = exp_vec();
      checks++;
      if (act !== exp || (gnt0 && gnt1)) begin
        errors++;
        $display("FAIL random cycle %0d: got %h required %h", n, act, exp);
      end
      reset = 1'b0;
      tick();
    end
    req0 = 0; req1 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_alternating();
    test_handover();
    test_tie_sequence();
    test_reset_mid_burst();
    test_read_passthrough();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
